// File: rtl/iord_exc_seq.sv
// Exception vector fetch sequencer: muxes the normal memory address, and on an
// exception request reads the vector byte and presents it as the new PC.
module iord_exc_seq #(
    parameter int WIDTH    = 32,
    parameter int NUM_EXC  = 3,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         sel,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic [WIDTH-1:0]   result,
    input  logic [NUM_EXC-1:0] exc_req,
    input  logic [7:0]         mem_data,
    output logic [WIDTH-1:0]   addr,
    output logic               busy,
    output logic               pc_load,
    output logic [WIDTH-1:0]   pc_target,
    output logic [WIDTH-1:0]   epc,
    output logic [2:0]         exc_code
);

    typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;

    state_t           state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic             busy_n, pc_load_n;
    logic [WIDTH-1:0] pc_target_n, epc_n;
    logic [2:0]       exc_code_n;

    // Fixed priority: lowest set request index wins, higher ones are dropped.
    function automatic logic [2:0] lowest_idx(input logic [NUM_EXC-1:0] req);
        lowest_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (req[i]) lowest_idx = 3'(i);
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            epc       <= '0;
            exc_code  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            pc_load   <= pc_load_n;
            pc_target <= pc_target_n;
            epc       <= epc_n;
            exc_code  <= exc_code_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        busy_n      = busy;
        pc_load_n   = 1'b0;
        pc_target_n = pc_target;
        epc_n       = epc;
        exc_code_n  = exc_code;
        case (state)
            IDLE: begin
                if (|exc_req) begin
                    state_n    = WAIT;
                    busy_n     = 1'b1;
                    exc_code_n = lowest_idx(exc_req);
                    epc_n      = pc - WIDTH'(4);
                    cnt_n      = 3'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                // Counter reaching zero marks the last cycle of memory latency.
                if (cnt == 3'd0) begin
                    state_n     = LOAD;
                    pc_load_n   = 1'b1;
                    pc_target_n = WIDTH'(mem_data);
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            LOAD: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_comb begin
        addr = '0;
        if (state == IDLE) begin
            case (sel)
                2'd0:    addr = pc;
                2'd1:    addr = alu_out;
                2'd2:    addr = result;
                default: addr = '0;
            endcase
        end else begin
            addr = WIDTH'(VEC_BASE) + WIDTH'(exc_code);
        end
    end

endmodule

// File: tb/tb_iord_exc_seq.sv
// Directed bench for iord_exc_seq: default instance plus a narrow,
// single-cycle-latency instance.
module tb_iord_exc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic [31:0] pc, alu_out, result;
    logic [2:0]  exc_req;
    logic [7:0]  mem_data;
    logic [31:0] addr, pc_target, epc;
    logic        busy, pc_load;
    logic [2:0]  exc_code;

    logic [1:0]  sel2;
    logic [15:0] pc2, alu2, res2;
    logic [3:0]  exc_req2;
    logic [7:0]  mem_data2;
    logic [15:0] addr2, pc_target2, epc2;
    logic        busy2, pc_load2;
    logic [2:0]  exc_code2;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    iord_exc_seq dut (
        .clk(clk), .reset(reset), .sel(sel), .pc(pc), .alu_out(alu_out),
        .result(result), .exc_req(exc_req), .mem_data(mem_data), .addr(addr),
        .busy(busy), .pc_load(pc_load), .pc_target(pc_target), .epc(epc),
        .exc_code(exc_code)
    );

    iord_exc_seq #(.WIDTH(16), .NUM_EXC(4), .VEC_BASE(8'h80), .MEM_LAT(1)) dut2 (
        .clk(clk), .reset(reset), .sel(sel2), .pc(pc2), .alu_out(alu2),
        .result(res2), .exc_req(exc_req2), .mem_data(mem_data2), .addr(addr2),
        .busy(busy2), .pc_load(pc_load2), .pc_target(pc_target2), .epc(epc2),
        .exc_code(exc_code2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mux_exp [4];
        mux_exp = '{32'h100, 32'h200, 32'h300, 32'h0};

        reset = 1'b1; sel = 2'd0; pc = 32'h100; alu_out = 32'h200; result = 32'h300;
        exc_req = '0; mem_data = 8'h00;
        sel2 = 2'd0; pc2 = 16'h1234; alu2 = 16'h2222; res2 = 16'h3333;
        exc_req2 = '0; mem_data2 = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and address mux
        check("rst_busy", busy, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_target", pc_target, 0);
        check("rst_epc", epc, 0);
        check("rst_exc_code", exc_code, 0);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check($sformatf("mux_sel%0d", s), addr, mux_exp[s]);
        end

        // Single exception, MEM_LAT=2
        sel = 2'd0; pc = 32'h40; exc_req = 3'b010; mem_data = 8'h7C;
        tick();
        exc_req = '0;
        #1;
        check("s_w1_addr", addr, 254);
        check("s_w1_busy", busy, 1);
        check("s_w1_pc_load", pc_load, 0);
        check("s_epc", epc, 32'h3C);
        check("s_exc_code", exc_code, 1);
        tick();
        check("s_w2_addr", addr, 254);
        check("s_w2_busy", busy, 1);
        check("s_w2_pc_load", pc_load, 0);
        tick();
        check("s_ld_addr", addr, 254);
        check("s_ld_pc_load", pc_load, 1);
        check("s_ld_busy", busy, 1);
        check("s_pc_target", pc_target, 32'h7C);
        tick();
        check("s_idle_busy", busy, 0);
        check("s_idle_pc_load", pc_load, 0);
        check("s_hold_target", pc_target, 32'h7C);
        check("s_idle_addr", addr, 32'h40);

        // Priority and requests ignored while busy
        pc = 32'h500; exc_req = 3'b110; mem_data = 8'h55;
        tick();
        exc_req = 3'b001;
        #1;
        check("p_exc_code", exc_code, 1);
        check("p_addr", addr, 254);
        check("p_epc", epc, 32'h4FC);
        tick();
        exc_req = 3'b100;
        tick();
        check("p_ld_pc_load", pc_load, 1);
        check("p_pc_target", pc_target, 32'h55);
        exc_req = '0;
        tick();
        check("p_idle_busy", busy, 0);
        tick();
        check("p_no_refetch_busy", busy, 0);
        check("p_no_refetch_pc_load", pc_load, 0);
        check("p_hold_exc_code", exc_code, 1);

        // Reset in the second WAIT cycle
        pc = 32'h80; exc_req = 3'b001; mem_data = 8'h99;
        tick();
        exc_req = '0;
        check("r_w1_busy", busy, 1);
        tick();
        check("r_w2_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; sel = 2'd1;
        #1;
        check("r_busy", busy, 0);
        check("r_pc_load", pc_load, 0);
        check("r_epc", epc, 0);
        check("r_exc_code", exc_code, 0);
        check("r_pc_target", pc_target, 0);
        check("r_addr", addr, 32'h200);
        tick();
        check("r_later_pc_load", pc_load, 0);
        check("r_later_busy", busy, 0);
        tick();
        check("r_later2_pc_load", pc_load, 0);

        // Wrap-around epc and back-to-back fetch with request held
        sel = 2'd0; pc = 32'h0; exc_req = 3'b001; mem_data = 8'hA5;
        tick();
        check("w_epc", epc, 32'hFFFF_FFFC);
        check("w_addr", addr, 253);
        check("w_exc_code", exc_code, 0);
        tick();
        tick();
        check("w_ld_pc_load", pc_load, 1);
        check("w_pc_target", pc_target, 32'hA5);
        pc = 32'h10; mem_data = 8'h3E;
        tick();
        check("w_gap_busy", busy, 0);
        check("w_gap_pc_load", pc_load, 0);
        tick();
        exc_req = '0;
        check("w_2nd_busy", busy, 1);
        check("w_2nd_epc", epc, 32'hC);
        tick();
        tick();
        check("w_2nd_pc_load", pc_load, 1);
        check("w_2nd_pc_target", pc_target, 32'h3E);
        tick();
        check("w_2nd_idle_busy", busy, 0);

        // Narrow instance, MEM_LAT=1
        sel2 = 2'd2; pc2 = 16'h0020; exc_req2 = 4'b1000; mem_data2 = 8'hF0;
        tick();
        exc_req2 = '0;
        check("n_addr", addr2, 16'h0083);
        check("n_busy", busy2, 1);
        check("n_w_pc_load", pc_load2, 0);
        check("n_exc_code", exc_code2, 3);
        check("n_epc", epc2, 16'h001C);
        tick();
        check("n_pc_load", pc_load2, 1);
        check("n_pc_target", pc_target2, 16'h00F0);
        tick();
        check("n_idle_pc_load", pc_load2, 0);
        check("n_idle_busy", busy2, 0);
        check("n_idle_addr", addr2, 16'h3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
